// File: rtl/disp_pkg.sv
// Shared state encoding and default geometry for the display frame fetcher.
package disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRST,
    S_WAITBUF,
    S_ADDR,
    S_DATA
  } fetch_state_t;

  localparam int unsigned DEF_H_PIX      = 640;
  localparam int unsigned DEF_V_LINE     = 480;
  localparam int unsigned DEF_BURST_LEN  = 16;
  localparam int unsigned BYTES_PER_BEAT = 8;

endpackage

// File: rtl/disp_fetch_addr.sv
// Frame base register, burst counter and running burst address for disp_fetch.
module disp_fetch_addr
  import disp_pkg::*;
#(
  parameter int unsigned H_PIX     = DEF_H_PIX,
  parameter int unsigned V_LINE    = DEF_V_LINE,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        load,
  input  logic [31:0] base_in,
  input  logic        inc,
  output logic [31:0] burst_addr,
  output logic        frame_done
);

  localparam int unsigned TOTAL_BEATS = H_PIX * V_LINE / 2;
  localparam int unsigned N_BURSTS    = TOTAL_BEATS / BURST_LEN;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BYTES_PER_BEAT);
  localparam logic [31:0] LAST_IDX    = 32'(N_BURSTS - 1);

  logic [31:0] base_q;
  logic [31:0] offset_q;
  logic [31:0] burst_idx;

  // Offset is accumulated per burst instead of multiplying burst_idx.
  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      base_q    <= '0;
      offset_q  <= '0;
      burst_idx <= '0;
    end else if (load) begin
      base_q    <= base_in;
      offset_q  <= '0;
      burst_idx <= '0;
    end else if (inc) begin
      offset_q  <= offset_q + BURST_BYTES;
      burst_idx <= burst_idx + 32'd1;
    end
  end

  assign burst_addr = base_q + offset_q;
  // High while the burst in flight is the last one of the frame.
  assign frame_done = (burst_idx == LAST_IDX);

endmodule

// File: rtl/disp_fetch.sv
// Display frame fetcher: AXI burst reads of a frame into the pixel FIFO.
// Optional RLAST/beat-count checker with ERR output under `DISP_FETCH_CHECK_EN.
module disp_fetch
  import disp_pkg::*;
#(
  parameter int unsigned H_PIX     = DEF_H_PIX,
  parameter int unsigned V_LINE    = DEF_V_LINE,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned RST_CYC   = 4
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic [31:0] DISPADDR,
  input  logic        VSTART,
  input  logic        BUF_WREADY,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RVALID,
  input  logic        RLAST,
  output logic        RREADY,
  output logic        FIFORST,
  output logic [63:0] FIFOIN,
  output logic        FIFOWR,
  output logic        BUSY
`ifdef DISP_FETCH_CHECK_EN
  ,
  output logic        ERR
`endif
);

  fetch_state_t state;
  logic [31:0]  rst_cnt;
  logic         load;
  logic         beat;
  logic         last_beat;
  logic [31:0]  burst_addr;
  logic         frame_done;

  assign load      = (state == S_IDLE) && VSTART && DISPON;
  assign beat      = RVALID && RREADY;
  assign last_beat = beat && RLAST;

  assign ARLEN  = 8'(BURST_LEN - 1);
  assign FIFOWR = beat;
  assign FIFOIN = RDATA;

  disp_fetch_addr #(
    .H_PIX     (H_PIX),
    .V_LINE    (V_LINE),
    .BURST_LEN (BURST_LEN)
  ) u_addr (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .load       (load),
    .base_in    (DISPADDR),
    .inc        (last_beat),
    .burst_addr (burst_addr),
    .frame_done (frame_done)
  );

  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      state   <= S_IDLE;
      rst_cnt <= '0;
      ARADDR  <= '0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      FIFORST <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (load) begin
          state   <= S_FRST;
          rst_cnt <= '0;
          FIFORST <= 1'b1;
          BUSY    <= 1'b1;
        end
        S_FRST: if (rst_cnt == 32'(RST_CYC - 1)) begin
          FIFORST <= 1'b0;
          state   <= S_WAITBUF;
        end else begin
          rst_cnt <= rst_cnt + 32'd1;
        end
        S_WAITBUF: if (!DISPON) begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end else if (BUF_WREADY) begin
          state   <= S_ADDR;
          ARVALID <= 1'b1;
          ARADDR  <= burst_addr;
        end
        S_ADDR: if (ARREADY) begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b1;
          state   <= S_DATA;
        end
        // RLAST alone ends the burst; DISPON is only honoured at that point.
        S_DATA: if (last_beat) begin
          RREADY <= 1'b0;
          if (frame_done || !DISPON) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            state <= S_WAITBUF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DISP_FETCH_CHECK_EN
  logic [4:0] beat_cnt;

  // Flags RLAST on the wrong beat, or a full burst's worth of beats without it.
  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      beat_cnt <= '0;
      ERR      <= 1'b0;
    end else begin
      if (load) begin
        ERR <= 1'b0;
      end else if (beat && (RLAST != (beat_cnt == 5'(BURST_LEN - 1)))) begin
        ERR <= 1'b1;
      end
      if (load || last_beat) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 5'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_fetch.sv
// Randomized scoreboard bench for disp_fetch with an AXI read slave model.
module tb_disp_fetch;
  import disp_pkg::*;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 16;
  localparam int unsigned BL    = 16;
  localparam int unsigned RC    = 4;
  localparam int unsigned TOTAL = H * V / 2;
  localparam int unsigned NB    = TOTAL / BL;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b0;
  logic        DISPON = 1'b0;
  logic [31:0] DISPADDR = '0;
  logic        VSTART = 1'b0;
  logic        BUF_WREADY = 1'b1;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [63:0] RDATA = '0;
  logic        RVALID = 1'b0;
  logic        RLAST = 1'b0;
  logic        RREADY;
  logic        FIFORST;
  logic [63:0] FIFOIN;
  logic        FIFOWR;
  logic        BUSY;
`ifdef DISP_FETCH_CHECK_EN
  logic        ERR;
`endif

  disp_fetch #(
    .H_PIX     (H),
    .V_LINE    (V),
    .BURST_LEN (BL),
    .RST_CYC   (RC)
  ) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .DISPON     (DISPON),
    .DISPADDR   (DISPADDR),
    .VSTART     (VSTART),
    .BUF_WREADY (BUF_WREADY),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RLAST      (RLAST),
    .RREADY     (RREADY),
    .FIFORST    (FIFORST),
    .FIFOIN     (FIFOIN),
    .FIFOWR     (FIFOWR),
    .BUSY       (BUSY)
`ifdef DISP_FETCH_CHECK_EN
    ,
    .ERR        (ERR)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_ar[$];
  logic [63:0] exp_fifo[$];
  bit          sb_on = 1'b1;

  int wr_cnt = 0, frst_cnt = 0, hs_cnt = 0, outstanding = 0;
  int w0 = 0, f0 = 0, h0 = 0;

  int ar_delay = -1;
  bit gap_on = 1'b1;
  bit buf_test = 1'b0;
  int buf_base = 0;
  int buf_block = 0;
  int sl_bursts = 0;
  int err_req = 0, err_served = 0;

  int          st = 0, cnt = 0, beat = 0, last_idx = 0;
  logic [31:0] sl_addr = '0;

  function automatic logic [63:0] mkdata(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Memory model: each 8-byte word holds a tag derived from its own address.
  task automatic present();
    if (gap_on && ($urandom_range(0, 3) == 0)) begin
      RVALID = 1'b0;
      RLAST  = 1'b0;
    end else begin
      RVALID = 1'b1;
      RDATA  = mkdata(sl_addr + 32'(beat * 8));
      RLAST  = (beat == last_idx);
    end
  endtask

  initial begin : slave
    bit acc, hs;
    forever begin
      @(negedge ACLK);
      acc = RVALID && RREADY;
      hs  = ARVALID && ARREADY;
      @(posedge ACLK);
      #1;
      if (!ARST) begin
        st = 0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        buf_block = 0; BUF_WREADY = 1'b1;
        continue;
      end
      if (buf_block > 0) begin
        buf_block--;
        if (buf_block == 0) BUF_WREADY = 1'b1;
      end
      case (st)
        0: if (ARVALID) begin
          sl_addr = ARADDR;
          cnt = (ar_delay < 0) ? int'($urandom_range(0, 3)) : ar_delay;
          if (cnt == 0) begin ARREADY = 1'b1; st = 2; end
          else st = 1;
        end
        1: begin
          cnt--;
          if (cnt == 0) begin ARREADY = 1'b1; st = 2; end
        end
        2: if (hs) begin
          ARREADY = 1'b0;
          beat = 0;
          last_idx = (err_req > err_served) ? int'(BL) - 2 : int'(BL) - 1;
          if (err_req > err_served) err_served++;
          st = 3;
          present();
        end
        3: begin
          if (acc) begin
            if (RLAST) begin
              RVALID = 1'b0; RLAST = 1'b0; st = 0; sl_bursts++;
              if (buf_test && (sl_bursts - buf_base == 4)) begin
                BUF_WREADY = 1'b0; buf_block = 100;
              end
            end else begin
              beat++;
            end
          end
          if (st == 3) present();
        end
        default: st = 0;
      endcase
    end
  end

  initial begin : monitor
    logic [31:0] prev_addr;
    bit prev_wait;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge ACLK);
      if (!ARST) begin
        outstanding = 0;
        prev_wait = 1'b0;
      end else begin
        if (FIFORST) frst_cnt++;
        if (buf_block > 0) check("no_ar_in_buf_window", ARVALID, 0);
        if (prev_wait) begin
          check("arvalid_stable", ARVALID, 1);
          check("araddr_stable", ARADDR, prev_addr);
        end
        if (ARVALID && ARREADY) begin
          hs_cnt++;
          check("single_outstanding", outstanding, 0);
          outstanding = 1;
          check("arlen", ARLEN, 64'(BL - 1));
          if (sb_on) begin
            if (exp_ar.size() == 0) fail("ar_unexpected");
            else check("araddr", ARADDR, exp_ar.pop_front());
          end
        end
        prev_wait = ARVALID && !ARREADY;
        prev_addr = ARADDR;
        if (RVALID) check("fifowr_eq_rvalid_rready", FIFOWR, RREADY);
        if (FIFOWR) begin
          wr_cnt++;
          if (sb_on) begin
            if (exp_fifo.size() == 0) fail("fifo_unexpected");
            else check("fifoin", FIFOIN, exp_fifo.pop_front());
          end
        end
        if (RVALID && RREADY && RLAST) outstanding = 0;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic [31:0] base);
    @(posedge ACLK);
    #1;
    w0 = wr_cnt; f0 = frst_cnt; h0 = hs_cnt;
    for (int unsigned b = 0; b < NB; b++) exp_ar.push_back(base + 32'(b * BL * 8));
    for (int unsigned j = 0; j < TOTAL; j++) exp_fifo.push_back(mkdata(base + 32'(j * 8)));
    DISPADDR = base;
    VSTART = 1'b1;
    @(posedge ACLK);
    #1;
    VSTART = 1'b0;
    DISPADDR = ~base;
    check("busy_after_vstart", BUSY, 1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge ACLK);
      #2;
      if (!BUSY) return;
    end
    fail("frame_timeout");
  endtask

  task automatic wait_writes(input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge ACLK);
      #2;
      if (wr_cnt - w0 >= n) return;
    end
    fail("writes_timeout");
  endtask

  task automatic frame_checks(input int exp_w, input int exp_b);
    check("frame_writes", wr_cnt - w0, exp_w);
    check("frame_bursts", hs_cnt - h0, exp_b);
    check("fiforst_cycles", frst_cnt - f0, RC);
    check("busy_idle", BUSY, 0);
    check("ar_left", exp_ar.size(), NB - exp_b);
    check("fifo_left", exp_fifo.size(), TOTAL - exp_w);
    exp_ar.delete();
    exp_fifo.delete();
  endtask

  initial begin : main
    #12;
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_fifowr", FIFOWR, 0);
    check("rst_fiforst", FIFORST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_araddr", ARADDR, 0);
    check("arlen_const", ARLEN, 64'(BL - 1));
`ifdef DISP_FETCH_CHECK_EN
    check("rst_err", ERR, 0);
`endif
    @(posedge ACLK);
    #1;
    ARST = 1'b1;
    DISPON = 1'b1;
    repeat (3) @(posedge ACLK);

    // Full frame with a stray VSTART part-way through.
    start_frame(32'h2000_0000);
    wait_writes(20, 2000);
    #1;
    DISPADDR = 32'h1234_0000;
    VSTART = 1'b1;
    @(posedge ACLK);
    #1;
    VSTART = 1'b0;
    wait_idle(5000);
    frame_checks(TOTAL, NB);
`ifdef DISP_FETCH_CHECK_EN
    check("err_clean_frame", ERR, 0);
`endif

    // Slow ARREADY, no data gaps.
    ar_delay = 5;
    gap_on = 1'b0;
    start_frame($urandom & 32'hFFFF_FF80);
    wait_idle(5000);
    frame_checks(TOTAL, NB);

    // FIFO back-pressure after burst 3, with address wrap past 2^32.
    ar_delay = -1;
    gap_on = 1'b1;
    buf_base = sl_bursts;
    buf_test = 1'b1;
    start_frame(32'hFFFF_FE00);
    wait_idle(5000);
    frame_checks(TOTAL, NB);
    buf_test = 1'b0;

    // DISPON dropped mid burst 2: that burst completes, then idle.
    start_frame(32'h3000_0000);
    wait_writes(2 * BL + 7, 2000);
    DISPON = 1'b0;
    wait_idle(2000);
    frame_checks(3 * BL, 3);
    DISPON = 1'b1;
    h0 = hs_cnt;
    repeat (20) @(posedge ACLK);
    #2;
    check("stay_idle_busy", BUSY, 0);
    check("stay_idle_no_ar", hs_cnt - h0, 0);

    // Asynchronous reset in the middle of a burst.
    start_frame(32'h4000_0000);
    wait_writes(BL + 5, 2000);
    #1;
    ARST = 1'b0;
    #1;
    check("arst_arvalid", ARVALID, 0);
    check("arst_rready", RREADY, 0);
    check("arst_fifowr", FIFOWR, 0);
    check("arst_fiforst", FIFORST, 0);
    check("arst_busy", BUSY, 0);
    check("arst_araddr", ARADDR, 0);
    exp_ar.delete();
    exp_fifo.delete();
    repeat (3) @(posedge ACLK);
    #1;
    ARST = 1'b1;
    repeat (2) @(posedge ACLK);
    start_frame(32'h5000_0000);
    wait_idle(5000);
    frame_checks(TOTAL, NB);

`ifdef DISP_FETCH_CHECK_EN
    // Early RLAST on the first burst of a frame.
    err_req++;
    sb_on = 1'b0;
    start_frame(32'h6000_0000);
    wait_idle(5000);
    exp_ar.delete();
    exp_fifo.delete();
    sb_on = 1'b1;
    check("err_set", ERR, 1);
    repeat (10) @(posedge ACLK);
    #1;
    check("err_sticky", ERR, 1);
    start_frame(32'h7000_0000);
    check("err_clear_frst", ERR, 0);
    wait_idle(5000);
    frame_checks(TOTAL, NB);
    check("err_stays_clear", ERR, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
